y_fetch_unit: RTL and testbench

//  Instruction-fetch front end for the yChip datapath: owns the PC, issues word reads
//  to instruction memory, and buffers returned words (tagged with their PC) for the

---
 rtl/y_fetch_unit_if.sv | 29 ++
 rtl/y_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_y_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/y_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response and the decode-side
// instruction handshake. "master" is the fetch unit, "slave" is memory + decode.
interface y_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output ins_valid, ins, ins_pc,
        input  ins_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  ins_valid, ins, ins_pc,
        output ins_ready
    );
endinterface

// File: rtl/y_fetch_unit.sv
// yChip instruction-fetch front end: PC, one-deep memory request tracking and a
// PC-tagged instruction FIFO. Define FETCH_PERF_EN to add fetch/drop counters.
module y_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] entryPoint,
    input  logic        INT,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    y_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [31:0]      pc_r;
    logic [31:0]      req_pc_r;
    logic             inflight_r;
    logic             drop_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [31:0]      ins_mem_r [DEPTH];
    logic [31:0]      pc_mem_r  [DEPTH];

    logic flush_s;
    logic credit_ok_s;
    logic req_valid_s;
    logic fire_s;
    logic push_s;
    logic pop_s;
    logic ins_valid_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode; a flush cycle neither requests, pushes nor pops.
    always_comb begin
        flush_s     = !reset && (INT || redirect_valid);
        credit_ok_s = (32'(count_r) + 32'(inflight_r)) < 32'(DEPTH);
        req_valid_s = !reset && !INT && !redirect_valid && credit_ok_s;
        fire_s      = req_valid_s && bus.imem_req_ready;
        push_s      = !reset && bus.imem_rsp_valid && !drop_r && !flush_s;
        ins_valid_s = !reset && (count_r != '0);
        pop_s       = ins_valid_s && bus.ins_ready && !flush_s;
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_r;
    assign bus.ins_valid      = ins_valid_s;
    assign bus.ins            = ins_valid_s ? ins_mem_r[rd_ptr_r] : 32'h0;
    assign bus.ins_pc         = ins_valid_s ? pc_mem_r[rd_ptr_r]  : 32'h0;

    // Program counter with reset > INT > redirect > sequential priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (INT) begin
            pc_r <= entryPoint & ~32'h3;
        end else if (redirect_valid) begin
            pc_r <= redirect_pc & ~32'h3;
        end else if (fire_s) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Outstanding-request tracking. A response landing in the flush cycle itself is
    // discarded there, so drop only arms for a request still open after this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_r   <= 32'h0;
            inflight_r <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            req_pc_r   <= fire_s ? pc_r : req_pc_r;
            inflight_r <= fire_s ? 1'b1 : (bus.imem_rsp_valid ? 1'b0 : inflight_r);
            if (flush_s) begin
                drop_r <= inflight_r && !bus.imem_rsp_valid;
            end else if (bus.imem_rsp_valid && drop_r) begin
                drop_r <= 1'b0;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    // FIFO occupancy and pointers; flush discards every buffered entry.
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            count_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO payload storage, tagged with the PC of the request that produced it.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ins_mem_r[wr_ptr_r] <= bus.imem_rsp_data;
            pc_mem_r[wr_ptr_r]  <= req_pc_r;
        end
    end

`ifdef FETCH_PERF_EN
    logic discard_s;
    assign discard_s = !reset && bus.imem_rsp_valid && (drop_r || flush_s);

    // Performance counters: pushes, and discarded responses plus flushed entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'h0;
            perf_dropped <= 32'h0;
        end else begin
            perf_fetched <= perf_fetched + (push_s ? 32'h1 : 32'h0);
            perf_dropped <= perf_dropped + (discard_s ? 32'h1 : 32'h0)
                          + (flush_s ? 32'(count_r) : 32'h0);
        end
    end
`endif
endmodule

// File: tb/tb_y_fetch_unit.sv
// Directed bench for y_fetch_unit: fixed-latency memory model, cycle-exact request
// checks and a PC scoreboard for instructions consumed by decode.
module tb_y_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        INT;
    logic        redirect_valid;
    logic [31:0] entryPoint;
    logic [31:0] redirect_pc;
    y_fetch_unit_if bus();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] drop_base;
`endif

    y_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .reset          (reset),
        .entryPoint     (entryPoint),
        .INT            (INT),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory: answers every accepted request exactly one cycle later.
    always @(posedge clk) begin
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            bus.imem_rsp_valid <= 1'b1;
            bus.imem_rsp_data  <= mem_word(bus.imem_req_addr);
        end else begin
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Settle just before the next rising edge, then score any consumed instruction.
    task automatic look();
        logic [31:0] pc;
        #4;
        if (!reset && !INT && !redirect_valid && bus.ins_valid && bus.ins_ready) begin
            n_run++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed pc %h expected no instruction", bus.ins_pc);
            end
            if (exp_q.size() != 0) begin
                pc = exp_q.pop_front();
                chk("sb_pc", bus.ins_pc, pc);
                chk("sb_ins", bus.ins, mem_word(pc));
            end
        end
    endtask

    initial begin
        reset = 1'b1; INT = 1'b0; redirect_valid = 1'b0;
        entryPoint = 32'h0; redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b1; bus.ins_ready = 1'b1;

        // Reset, then INT to 0x28 with decode always ready
        cyc(); look();
        chk("rst_req_valid", bus.imem_req_valid, 32'h0);
        chk("rst_ins_valid", bus.ins_valid, 32'h0);
        chk("rst_ins", bus.ins, 32'h0);
        chk("rst_ins_pc", bus.ins_pc, 32'h0);
        cyc(); look();
        chk("rst2_req_valid", bus.imem_req_valid, 32'h0);
        cyc(); reset = 1'b0; INT = 1'b1; entryPoint = 32'h28; look();
        chk("t1_int_req", bus.imem_req_valid, 32'h0);
        cyc(); INT = 1'b0; look();
        chk("t1_req0_valid", bus.imem_req_valid, 32'h1);
        chk("t1_req0_addr", bus.imem_req_addr, 32'h28); exp_q.push_back(32'h28);
        cyc(); look();
        chk("t1_req1_addr", bus.imem_req_addr, 32'h2C); exp_q.push_back(32'h2C);
        chk("t1_lat_empty", bus.ins_valid, 32'h0);
        cyc(); look();
        chk("t1_lat_valid", bus.ins_valid, 32'h1);
        chk("t1_lat_pc", bus.ins_pc, 32'h28);
        chk("t1_credit_stall", bus.imem_req_valid, 32'h0);
        cyc(); look();
        chk("t1_req2_valid", bus.imem_req_valid, 32'h1);
        chk("t1_req2_addr", bus.imem_req_addr, 32'h30); exp_q.push_back(32'h30);

        // Credit limit with decode stalled
        cyc(); INT = 1'b1; entryPoint = 32'h28; bus.ins_ready = 1'b0; exp_q.delete(); look();
        chk("t2_int_req", bus.imem_req_valid, 32'h0);
        cyc(); INT = 1'b0; look();
        chk("t2_req0_addr", bus.imem_req_addr, 32'h28); exp_q.push_back(32'h28);
        cyc(); look();
        chk("t2_req1_valid", bus.imem_req_valid, 32'h1);
        chk("t2_req1_addr", bus.imem_req_addr, 32'h2C); exp_q.push_back(32'h2C);
        cyc(); look();
        chk("t2_full_req_a", bus.imem_req_valid, 32'h0);
        chk("t2_head_pc", bus.ins_pc, 32'h28);
        cyc(); look();
        chk("t2_full_req_b", bus.imem_req_valid, 32'h0);
        cyc(); bus.ins_ready = 1'b1; look();
        chk("t2_full_req_c", bus.imem_req_valid, 32'h0);
        cyc(); bus.ins_ready = 1'b0; look();
        chk("t2_pop_req_valid", bus.imem_req_valid, 32'h1);
        chk("t2_pop_req_addr", bus.imem_req_addr, 32'h30); exp_q.push_back(32'h30);
        chk("t2_head_after_pop", bus.ins_pc, 32'h2C);

        // Redirect with a response in flight and one entry buffered
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; exp_q.delete(); look();
        chk("t3_redir_req", bus.imem_req_valid, 32'h0);
`ifdef FETCH_PERF_EN
        drop_base = perf_dropped;
`endif
        cyc(); redirect_valid = 1'b0; bus.ins_ready = 1'b1; look();
        chk("t3_flushed", bus.ins_valid, 32'h0);
        chk("t3_addr", bus.imem_req_addr, 32'h100); exp_q.push_back(32'h100);
        chk("t3_req_valid", bus.imem_req_valid, 32'h1);
`ifdef FETCH_PERF_EN
        chk("t3_perf_dropped", perf_dropped, drop_base + 32'd2);
`endif
        cyc(); look();
        chk("t3_addr_next", bus.imem_req_addr, 32'h104); exp_q.push_back(32'h104);
        cyc(); look();
        chk("t3_ins_valid", bus.ins_valid, 32'h1);
        chk("t3_ins_pc", bus.ins_pc, 32'h100);

        // INT to a misaligned entry point
        cyc(); INT = 1'b1; entryPoint = 32'h2B; exp_q.delete(); look();
        chk("t4_int_req", bus.imem_req_valid, 32'h0);
`ifdef FETCH_PERF_EN
        drop_base = perf_dropped;
`endif
        cyc(); INT = 1'b0; bus.imem_req_ready = 1'b0; look();
        chk("t4_aligned_pc", bus.imem_req_addr, 32'h28);
        chk("t4_req_valid", bus.imem_req_valid, 32'h1);
`ifdef FETCH_PERF_EN
        chk("t4_perf_dropped", perf_dropped, drop_base + 32'd1);
`endif

        // INT beats redirect; then reset mid-stream
        cyc(); INT = 1'b1; redirect_valid = 1'b1; entryPoint = 32'h28; redirect_pc = 32'h200; look();
        chk("t5_both_req", bus.imem_req_valid, 32'h0);
        cyc(); INT = 1'b0; redirect_valid = 1'b0; bus.imem_req_ready = 1'b1; look();
        chk("t5_int_wins", bus.imem_req_addr, 32'h28); exp_q.push_back(32'h28);
        cyc(); look();
        chk("t5_addr_next", bus.imem_req_addr, 32'h2C); exp_q.push_back(32'h2C);
        cyc(); reset = 1'b1; exp_q.delete(); look();
        chk("t5_rst_ins_valid", bus.ins_valid, 32'h0);
        chk("t5_rst_req_valid", bus.imem_req_valid, 32'h0);
        chk("t5_rst_ins_pc", bus.ins_pc, 32'h0);
        cyc(); reset = 1'b0; bus.imem_req_ready = 1'b0; look();
        chk("t5_reset_pc", bus.imem_req_addr, 32'h0);
        chk("t5_post_rst_empty", bus.ins_valid, 32'h0);
`ifdef FETCH_PERF_EN
        chk("t5_perf_fetched_clr", perf_fetched, 32'h0);
        chk("t5_perf_dropped_clr", perf_dropped, 32'h0);
`endif

        // PC wrap at the top of the address space
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; look();
        chk("t6_redir_req", bus.imem_req_valid, 32'h0);
        cyc(); redirect_valid = 1'b0; bus.imem_req_ready = 1'b1; look();
        chk("t6_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC); exp_q.push_back(32'hFFFF_FFFC);
        cyc(); look();
        chk("t6_wrap_addr", bus.imem_req_addr, 32'h0); exp_q.push_back(32'h0);
        chk("t6_wrap_valid", bus.imem_req_valid, 32'h1);
        cyc(); look();
        chk("t6_head_top", bus.ins_pc, 32'hFFFF_FFFC);
        cyc(); bus.imem_req_ready = 1'b0; look();
        chk("t6_head_wrap", bus.ins_pc, 32'h0);
        chk("t6_next_addr", bus.imem_req_addr, 32'h4);
        cyc(); look();
        chk("t6_drained_valid", bus.ins_valid, 32'h0);
        chk("t6_drained_ins", bus.ins, 32'h0);
        chk("t6_drained_pc", bus.ins_pc, 32'h0);
        chk("t6_sb_left", 32'(exp_q.size()), 32'h0);
`ifdef FETCH_PERF_EN
        chk("t6_perf_fetched", perf_fetched, 32'h2);
        chk("t6_perf_dropped", perf_dropped, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
